// File: rtl/cmsdk_apb4_eg_master.sv
// APB4 requester: turns one command into one APB transfer and returns one response.
// Every transfer runs IDLE -> SETUP -> ACCESS (with optional wait states) -> RESP.
module cmsdk_apb4_eg_master #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    // Both channels use valid/ready. A beat moves on a rising edge where valid
    // and ready are both high. The command channel is ready only in IDLE, and
    // the response channel is valid only in RESP. Neither side may retract a beat.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,
    input  logic [2:0]           cmd_prot,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [7:0]           rsp_waits,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   write_q, write_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             strb_q, strb_d;
    logic [2:0]             prot_q, prot_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [7:0]             waits_q, waits_d;

    logic accept;
    logic complete;

    assign accept   = cmd_valid && (state_q == ST_IDLE);
    assign complete = PREADY && (state_q == ST_ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            waits_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            waits_q <= waits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (PREADY) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured once at acceptance, so the APB side stays stable
    // however the command inputs move afterwards. Strobes are zeroed for reads here.
    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        waits_d = waits_q;
        if (accept) begin
            write_d = cmd_write;
            addr_d  = {cmd_addr[ADDRWIDTH-1:2], 2'b00};
            wdata_d = cmd_wdata;
            strb_d  = cmd_write ? cmd_strb : 4'b0000;
            prot_d  = cmd_prot;
            waits_d = 8'd0;
        end
        if (complete) begin
            rdata_d = write_q ? 32'd0 : PRDATA;
            err_d   = PSLVERR;
        end else if ((state_q == ST_ACCESS) && (waits_q != 8'hFF)) begin
            waits_d = waits_q + 8'd1;
        end
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        PENABLE   = (state_q == ST_ACCESS);
        rsp_valid = (state_q == ST_RESP);
    end

    assign PWRITE    = write_q;
    assign PADDR     = addr_q;
    assign PWDATA    = wdata_q;
    assign PSTRB     = strb_q;
    assign PPROT     = prot_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rsp_waits = waits_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cmsdk_apb4_eg_master.sv
// Self-checking bench for cmsdk_apb4_eg_master: directed cases plus random transfers
// against a per-transfer reference model; inputs and checks happen on the falling edge.
module tb_cmsdk_apb4_eg_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  rsp_waits;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [40:0] exp_q[$];

    always #5 PCLK = ~PCLK;

    cmsdk_apb4_eg_master #(.ADDRWIDTH(12)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_waits(rsp_waits), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_pins(input logic [11:0] paddr, input logic wr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot);
        check("paddr", PADDR, paddr);
        check("pwrite", PWRITE, wr);
        check("pwdata", PWDATA, wdata);
        check("pstrb", PSTRB, strb);
        check("pprot", PPROT, prot);
    endtask

    task automatic scramble_cmd();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 12'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    // One complete transfer; called on a falling edge with the DUT idle, returns on a falling edge.
    task automatic run_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int nwait,
                            input logic [31:0] rdata, input logic slverr, input int rdelay);
        logic [11:0] exp_paddr;
        logic [3:0]  exp_strb;
        logic [7:0]  exp_waits;
        logic [40:0] exp;
        exp_paddr = addr & 12'hFFC;
        exp_strb  = wr ? strb : 4'h0;
        exp_waits = (nwait > 255) ? 8'd255 : 8'(nwait);
        exp_q.push_back({slverr, exp_waits, wr ? 32'd0 : rdata});

        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
        @(posedge PCLK);
        @(negedge PCLK);
        scramble_cmd();
        check("setup_psel", PSEL, 1);
        check("setup_penable", PENABLE, 0);
        check("setup_cmd_ready", cmd_ready, 0);
        check("setup_rsp_valid", rsp_valid, 0);
        check_pins(exp_paddr, wr, wdata, exp_strb, prot);
        PREADY = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
        @(posedge PCLK);
        for (int k = 0; k <= nwait; k++) begin
            @(negedge PCLK);
            scramble_cmd();
            check("access_psel", PSEL, 1);
            check("access_penable", PENABLE, 1);
            check("access_rsp_valid", rsp_valid, 0);
            check_pins(exp_paddr, wr, wdata, exp_strb, prot);
            PREADY  = (k == nwait);
            PSLVERR = (k == nwait) ? slverr : 1'b1;
            PRDATA  = (k == nwait) ? rdata : $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge PCLK);
        end
        exp = exp_q.pop_front();
        for (int d = 0; d <= rdelay; d++) begin
            @(negedge PCLK);
            scramble_cmd();
            PREADY = 1'($urandom_range(0, 1));
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA = $urandom;
            check("resp_valid", rsp_valid, 1);
            check("resp_psel", PSEL, 0);
            check("resp_penable", PENABLE, 0);
            check("resp_cmd_ready", cmd_ready, 0);
            check("rsp_rdata", rsp_rdata, exp[31:0]);
            check("rsp_waits", rsp_waits, exp[39:32]);
            check("rsp_err", rsp_err, exp[40]);
            rsp_ready = (d == rdelay);
            @(posedge PCLK);
        end
        @(negedge PCLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        PREADY = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_waits", rsp_waits, 0);
        check_pins(12'h000, 1'b0, 32'h0, 4'h0, 3'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        run_xfer(1'b1, 12'h004, 32'hA5A5_1234, 4'hF, 3'h2, 0, 32'h0, 1'b0, 0);
        run_xfer(1'b0, 12'hFF7, 32'h1111_2222, 4'hA, 3'h5, 3, 32'hDEAD_BEEF, 1'b0, 1);
        run_xfer(1'b0, 12'h123, 32'h0, 4'h0, 3'h0, 0, 32'h0BAD_F00D, 1'b1, 0);
        run_xfer(1'b0, 12'h124, 32'h0, 4'h0, 3'h0, 2, 32'h1234_5678, 1'b0, 0);
        run_xfer(1'b1, 12'h3C8, 32'hCAFE_0001, 4'h5, 3'h7, 300, 32'h0, 1'b0, 5);

        for (int t = 0; t < 25; t++) begin
            run_xfer(1'($urandom_range(0, 1)), 12'($urandom), $urandom, 4'($urandom),
                     3'($urandom), $urandom_range(0, 5), $urandom,
                     1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Abandon a read in the middle of its wait states.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h101;
        cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hF; cmd_prot = 3'h3;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_in_access", PENABLE, 1);
        @(posedge PCLK);
        @(negedge PCLK);
        #1 PRESETn = 1'b0;
        #1;
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_waits", rsp_waits, 0);
        check_pins(12'h000, 1'b0, 32'h0, 4'h0, 3'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            check("post_abort_rsp_valid", rsp_valid, 0);
            check("post_abort_cmd_ready", cmd_ready, 1);
            check("post_abort_psel", PSEL, 0);
        end
        PREADY = 1'b0;
        rsp_ready = 1'b0;

        run_xfer(1'b1, 12'h010, 32'h0F0F_0F0F, 4'h3, 3'h1, 1, 32'h0, 1'b1, 2);

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
